// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream logic.
package async_fifo_pkg;

    localparam int DSIZE_DEF  = 8;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: captures FIFO read data at the tail and presents
// the head as a registered valid/data pair.
module fifo_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             i_capture,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [DSIZE-1:0] i_wdata,
    output occ_e             o_occ,
    output logic             o_valid,
    output logic [DSIZE-1:0] o_head
);

    logic [DSIZE-1:0] r_mem [SKID_DEPTH];
    occ_e             r_occ;
    logic             r_head_ptr;
    logic             r_valid;
    logic [DSIZE-1:0] r_head_data;

    logic             w_tail;
    logic             w_head_ptr_next;
    logic             w_valid_next;
    logic [DSIZE-1:0] w_head_data_next;

    // With one entry buffered the tail is the slot after the head; with zero
    // or two it coincides with the head (two only ever captures alongside a pop).
    assign w_tail          = r_head_ptr ^ (r_occ == OCC_1);
    assign w_head_ptr_next = r_head_ptr ^ i_pop;
    assign w_valid_next    = i_capture | (r_occ == OCC_2) | ((r_occ == OCC_1) & ~i_pop);

    always_comb begin
        w_head_data_next = r_mem[w_head_ptr_next];
        if (i_capture && (w_tail == w_head_ptr_next)) begin
            w_head_data_next = i_wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (i_capture && !i_flush) begin
            r_mem[w_tail] <= i_wdata;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_occ       <= OCC_0;
            r_head_ptr  <= 1'b0;
            r_valid     <= 1'b0;
            r_head_data <= '0;
        end else if (i_flush) begin
            r_occ   <= OCC_0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_occ)
                OCC_0:   if (i_capture) r_occ <= OCC_1;
                OCC_1: begin
                    if (i_capture && !i_pop)      r_occ <= OCC_2;
                    else if (!i_capture && i_pop) r_occ <= OCC_0;
                end
                OCC_2:   if (i_pop && !i_capture) r_occ <= OCC_1;
                default: r_occ <= OCC_0;
            endcase
            r_head_ptr  <= w_head_ptr_next;
            r_valid     <= w_valid_next;
            r_head_data <= w_head_data_next;
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = r_valid;
    assign o_head  = r_head_data;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words into a skid buffer and
// streams them out. Define FIFO_RD_STATS_EN to build the statistics counters.
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             flush,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CNT_W-1:0] pop_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic r_inflight;
    occ_e w_occ;
    logic w_pop;
    logic w_room;

    assign w_pop  = m_valid & m_ready;
    // Buffered plus in-flight words below two leaves room for another pop.
    assign w_room = (w_occ == OCC_0) | ((w_occ == OCC_1) & ~r_inflight);
    assign rinc   = rrst_n & ~rempty & ~flush & (w_room | ((w_occ != OCC_0) & m_ready));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rinc;
        end
    end

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .i_capture (r_inflight),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .i_wdata   (rdata),
        .o_occ     (w_occ),
        .o_valid   (m_valid),
        .o_head    (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] r_pop_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_pop_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && !flush && (r_pop_cnt != '1)) begin
                r_pop_cnt <= r_pop_cnt + CNT_W'(1);
            end
            if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pop_cnt   = r_pop_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign pop_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO memory model, scoreboard of
// popped words, vector table plus random and reset sequences.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          flush = 1'b0;
    logic          rempty = 1'b1;
    logic          rinc;
    logic [DW-1:0] rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] pop_cnt;
    logic [CW-1:0] stall_cnt;

    fifo_rd_stream #(.DSIZE(DW), .CNT_W(CW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .flush     (flush),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .pop_cnt   (pop_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 rclk = ~rclk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    bit            force_empty = 1'b0;
    int            exp_pop = 0;
    int            exp_stall = 0;

    typedef struct {
        bit fe;
        bit rdy;
        bit fl;
        bit e_rinc;
        bit e_valid;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: sample at the falling edge, update the models after the rising edge.
    task automatic tick(input bit use_vec, input bit e_rinc, input bit e_valid);
        logic          s_rinc;
        logic          s_pop;
        logic          s_stall;
        logic          s_flush;
        logic [DW-1:0] w;
        w = '0;
        rempty = force_empty || (fifo_q.size() == 0);
        @(negedge rclk);
        s_rinc  = rinc;
        s_pop   = m_valid & m_ready;
        s_stall = m_valid & ~m_ready;
        s_flush = flush;
        chk("rinc_and_rempty", 32'(rinc & rempty), 32'd0);
        chk("sb_depth_le2", 32'(exp_q.size() <= 2), 32'd1);
        if (use_vec) begin
            chk("vec_rinc", 32'(rinc), 32'(e_rinc));
            chk("vec_m_valid", 32'(m_valid), 32'(e_valid));
        end
        if (m_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(m_valid), 32'd0);
            else                   chk("m_data", 32'(m_data), 32'(exp_q[0]));
        end
`ifdef FIFO_RD_STATS_EN
        chk("pop_cnt", 32'(pop_cnt), 32'(exp_pop));
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
        chk("pop_cnt_tied", 32'(pop_cnt), 32'd0);
        chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif
        if (s_rinc === 1'b1 && fifo_q.size() > 0) w = fifo_q.pop_front();
        @(posedge rclk);
        #1;
        if (s_flush) begin
            exp_q.delete();
        end else if (s_pop === 1'b1) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_pop++;
        end
        if (s_stall === 1'b1) exp_stall++;
        if (s_rinc === 1'b1) begin
            rdata = w;
            exp_q.push_back(w);
        end
    endtask

    initial begin
        for (int i = 1; i <= 40; i++) fifo_q.push_back(8'(i));

        // fe rdy fl | rinc valid
        vecs[0]  = '{0, 1, 0, 1, 0};
        vecs[1]  = '{0, 1, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 1, 1};
        vecs[3]  = '{0, 1, 0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 1, 1};
        vecs[8]  = '{0, 1, 0, 1, 1};
        vecs[9]  = '{1, 1, 0, 0, 1};
        vecs[10] = '{1, 1, 0, 0, 1};
        vecs[11] = '{1, 1, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 1};
        vecs[15] = '{0, 1, 1, 0, 1};
        vecs[16] = '{0, 1, 0, 1, 0};
        vecs[17] = '{0, 1, 0, 1, 0};
        vecs[18] = '{0, 1, 1, 0, 1};
        vecs[19] = '{0, 1, 0, 1, 0};
        vecs[20] = '{0, 1, 0, 1, 0};
        vecs[21] = '{0, 1, 0, 1, 1};

        // Reset state with data available: rinc must stay forced low.
        rempty  = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge rclk);
        #3;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_pop_cnt", 32'(pop_cnt), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;

        // Streaming, backpressure, rempty mid-stream, flush corner cases.
        for (int v = 0; v < 22; v++) begin
            force_empty = vecs[v].fe;
            m_ready     = vecs[v].rdy;
            flush       = vecs[v].fl;
            tick(1'b1, vecs[v].e_rinc, vecs[v].e_valid);
            $display("vec %0d: rinc=%0b m_valid=%0b m_data=%0d", v, rinc, m_valid, m_data);
        end
        flush = 1'b0;

        // Random backpressure and empty flag.
        for (int i = 0; i < 100; i++) begin
            while (fifo_q.size() < 4) fifo_q.push_back(8'($urandom_range(0, 255)));
            m_ready     = (i % 2 == 0) ^ ($urandom_range(0, 3) == 0);
            force_empty = ($urandom_range(0, 3) == 0);
            tick(1'b0, 1'b0, 1'b0);
        end
        force_empty = 1'b1;
        m_ready     = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_m_valid", 32'(m_valid), 32'd0);
        $display("random phase done: delivered=%0d", exp_pop);

        // Asynchronous reset mid-transfer, then clean restart.
        force_empty = 1'b0;
        while (fifo_q.size() < 20) fifo_q.push_back(8'($urandom_range(0, 255)));
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_rinc", 32'(rinc), 32'd0);
        chk("arst_pop_cnt", 32'(pop_cnt), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        exp_q.delete();
        exp_pop   = 0;
        exp_stall = 0;
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        rrst_n = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        $display("restart done: delivered=%0d", exp_pop);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
